axi_wr_packer: RTL and testbench

Upstream feeder for the AXI master/slave top level. Accepts a 32-bit valid/ready word stream and packs BEATS words into the 128-bit data_in bus. Drives a one-cycle start pulse with the write address and read-back address, then holds off new data until the master reports transaction completion. Keeps a running burst address and a transaction counter.

---
 rtl/axi_wr_packer_if.sv | 25 ++
 rtl/axi_wr_packer.sv | 120 ++++++++++++
 tb/tb_axi_wr_packer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_packer_if.sv
// Word-stream and transaction-command signals between the packer and the AXI master side.
// The slave modport is the packer's view; the master modport is the environment's view.
interface axi_wr_packer_if #(
    parameter int BEATS = 4
);
    logic                  s_valid;
    logic                  s_ready;
    logic [31:0]           s_data;
    logic                  s_last;
    logic                  start;
    logic [31:0]           waddr;
    logic [31:0]           raddr;
    logic [32*BEATS-1:0]   data_in;
    logic                  txn_done;

    modport slave (
        input  s_valid, s_data, s_last, txn_done,
        output s_ready, start, waddr, raddr, data_in
    );

    modport master (
        output s_valid, s_data, s_last, txn_done,
        input  s_ready, start, waddr, raddr, data_in
    );
endinterface

// File: rtl/axi_wr_packer.sv
// Packs BEATS 32-bit stream words into one wide bundle, issues a start pulse with the
// running address and waits for txn_done before accepting the next bundle.
module axi_wr_packer #(
    parameter int BEATS    = 4,
    parameter int ADDR_INC = 16,
    parameter int CNT_W    = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              base_load,
    input  logic [31:0]       base_addr,
    output logic              busy,
    output logic [CNT_W-1:0]  txn_count,
    axi_wr_packer_if.slave    bus
);
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_ISSUE, ST_WAIT} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   lane_idx_reg, lane_idx_next;
    logic [31:0]        run_addr_reg, run_addr_next;
    logic [31:0]        waddr_reg;
    logic [CNT_W-1:0]   txn_count_reg;
    logic               s_ready_reg, s_ready_next;
    logic               start_reg, start_next;
    logic               busy_reg, busy_next;
    logic               hs;
    logic               last_lane;
    logic               txn_fire;

    assign hs        = bus.s_valid & s_ready_reg;
    assign last_lane = (lane_idx_reg == IDX_W'(BEATS - 1));
    assign txn_fire  = (state_reg == ST_WAIT) && bus.txn_done;

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (hs) state_next = (BEATS == 1 || bus.s_last) ? ST_ISSUE : ST_FILL;
            ST_FILL:  if (hs && (last_lane || bus.s_last)) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (bus.txn_done) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with the state.
    always_comb begin
        s_ready_next = (state_next == ST_IDLE) || (state_next == ST_FILL);
        start_next   = (state_next == ST_ISSUE);
        busy_next    = (state_next == ST_ISSUE) || (state_next == ST_WAIT);
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            s_ready_reg <= 1'b0;
            start_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            s_ready_reg <= s_ready_next;
            start_reg   <= start_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        lane_idx_next = lane_idx_reg;
        run_addr_next = run_addr_reg;
        if (txn_fire) begin
            lane_idx_next = '0;
            run_addr_next = run_addr_reg + 32'(ADDR_INC);
        end else if (hs && state_reg == ST_IDLE) begin
            lane_idx_next = IDX_W'(1);
        end else if (hs && state_reg == ST_FILL) begin
            lane_idx_next = lane_idx_reg + IDX_W'(1);
        end
        if (state_reg == ST_IDLE && base_load) run_addr_next = base_addr;
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            lane_idx_reg  <= '0;
            run_addr_reg  <= '0;
            waddr_reg     <= '0;
            txn_count_reg <= '0;
        end else begin
            lane_idx_reg <= lane_idx_next;
            run_addr_reg <= run_addr_next;
            // A base_load coinciding with the final handshake must already show in waddr.
            if (state_next == ST_ISSUE) waddr_reg <= run_addr_next;
            if (txn_fire) txn_count_reg <= txn_count_reg + CNT_W'(1);
        end
    end

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
        logic [31:0] lane_reg;
        always_ff @(posedge aclk or negedge areset) begin
            if (!areset) begin
                lane_reg <= '0;
            end else if (hs && state_reg == ST_IDLE) begin
                lane_reg <= (gi == 0) ? bus.s_data : 32'h0;
            end else if (hs && state_reg == ST_FILL && lane_idx_reg == IDX_W'(gi)) begin
                lane_reg <= bus.s_data;
            end
        end
        assign bus.data_in[32*gi +: 32] = lane_reg;
    end

    assign bus.s_ready = s_ready_reg;
    assign bus.start   = start_reg;
    assign bus.waddr   = waddr_reg;
    assign bus.raddr   = waddr_reg;
    assign busy        = busy_reg;
    assign txn_count   = txn_count_reg;
endmodule

// File: tb/tb_axi_wr_packer.sv
// Self-checking bench for axi_wr_packer: directed scenarios plus randomized transactions
// checked against a transaction-level model of address, count and bundle contents.
module tb_axi_wr_packer;
    localparam int BEATS = 4;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic        base_load = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic        busy;
    logic [15:0] txn_count;

    axi_wr_packer_if #(.BEATS(BEATS)) bus ();

    axi_wr_packer #(.BEATS(BEATS), .ADDR_INC(16), .CNT_W(16)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .base_load (base_load),
        .base_addr (base_addr),
        .busy      (busy),
        .txn_count (txn_count),
        .bus       (bus)
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;
    logic [31:0] exp_addr  = 32'h0;
    logic [15:0] exp_count = 16'h0;

    // snapshots filled by the driver tasks
    bit           obs_timeout;
    logic         obs_start, obs_busy, obs_ready, obs_start_after, obs_busy_after;
    logic [127:0] obs_data;
    logic [31:0]  obs_waddr, obs_raddr;
    bit           obs_wait_start, obs_wait_ready;
    logic         obs_ready_done, obs_busy_done;
    logic [15:0]  obs_count_done;

    function automatic logic [127:0] pack(input logic [127:0] w, input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[32*i +: 32] = w[32*i +: 32];
        return r;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Sends n words (with random idle gaps) and snapshots the outputs just after the final handshake
    task automatic drive_words(input int n, input logic [127:0] w, input bit use_last,
                               input bit load_in_fill);
        int guard;
        obs_timeout = 0;
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b0;
            bus.s_data  = $urandom;
            repeat ($urandom_range(0, 2)) tick();
            bus.s_valid = 1'b1;
            bus.s_data  = w[32*i +: 32];
            bus.s_last  = use_last && (i == n - 1);
            guard = 0;
            while (bus.s_ready !== 1'b1 && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) obs_timeout = 1;
            tick();
            if (i == 0 && load_in_fill) begin
                base_load = 1'b1;
                base_addr = 32'h5000;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = $urandom;
        obs_start = bus.start;
        obs_busy  = busy;
        obs_ready = bus.s_ready;
        obs_data  = bus.data_in;
        obs_waddr = bus.waddr;
        obs_raddr = bus.raddr;
        tick();
        obs_start_after = bus.start;
        obs_busy_after  = busy;
    endtask

    // Holds WAIT for wait_cycles, then pulses txn_done and snapshots the result
    task automatic finish_txn(input int wait_cycles);
        obs_wait_start = 0;
        obs_wait_ready = 0;
        repeat (wait_cycles) begin
            tick();
            if (bus.start === 1'b1) obs_wait_start = 1;
            if (bus.s_ready === 1'b1) obs_wait_ready = 1;
        end
        bus.txn_done = 1'b1;
        tick();
        bus.txn_done   = 1'b0;
        base_load      = 1'b0;
        obs_ready_done = bus.s_ready;
        obs_busy_done  = busy;
        obs_count_done = txn_count;
    endtask

    task automatic test_reset();
        areset = 1'b0;
        repeat (3) tick();
        n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got=%b want=0", bus.s_ready); end
        n_checks++; if (bus.start !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b want=0", bus.start); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (bus.data_in !== 128'h0) begin n_fail++; $display("FAIL reset_data got=%h want=0", bus.data_in); end
        n_checks++; if (bus.waddr !== 32'h0 || bus.raddr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h/%h want=0", bus.waddr, bus.raddr); end
        n_checks++; if (txn_count !== 16'h0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", txn_count); end
        areset = 1'b1;
        repeat (2) tick();
        n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL idle_s_ready got=%b want=1", bus.s_ready); end
        $display("reset: released, s_ready=%b", bus.s_ready);
    endtask

    task automatic test_basic();
        logic [127:0] w;
        base_load = 1'b1; base_addr = 32'h1000;
        tick();
        base_load = 1'b0;
        exp_addr = 32'h1000;
        w = {32'h44, 32'h33, 32'h22, 32'h11};
        drive_words(4, w, 1'b0, 1'b0);
        n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL basic_handshake timeout got=1 want=0"); end
        n_checks++; if (obs_data !== 128'h00000044_00000033_00000022_00000011) begin n_fail++; $display("FAIL basic_data got=%h want=%h", obs_data, 128'h00000044_00000033_00000022_00000011); end
        n_checks++; if (obs_start !== 1'b1) begin n_fail++; $display("FAIL basic_start got=%b want=1", obs_start); end
        n_checks++; if (obs_start_after !== 1'b0) begin n_fail++; $display("FAIL basic_start_width got=%b want=0", obs_start_after); end
        n_checks++; if (obs_waddr !== 32'h1000 || obs_raddr !== 32'h1000) begin n_fail++; $display("FAIL basic_addr got=%h/%h want=00001000", obs_waddr, obs_raddr); end
        n_checks++; if (obs_busy !== 1'b1 || obs_busy_after !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b%b want=11", obs_busy, obs_busy_after); end
        n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL basic_s_ready got=%b want=0", obs_ready); end
        n_txn++;
        $display("txn %0d: waddr=%h data=%h", n_txn, obs_waddr, obs_data);
    endtask

    task automatic test_done();
        finish_txn(5);
        exp_count++; exp_addr += 32'd16;
        n_checks++; if (obs_wait_start) begin n_fail++; $display("FAIL wait_start got=1 want=0"); end
        n_checks++; if (obs_wait_ready) begin n_fail++; $display("FAIL wait_s_ready got=1 want=0"); end
        n_checks++; if (obs_count_done !== 16'd1) begin n_fail++; $display("FAIL done_count got=%0d want=1", obs_count_done); end
        n_checks++; if (obs_ready_done !== 1'b1 || obs_busy_done !== 1'b0) begin n_fail++; $display("FAIL done_ready_busy got=%b%b want=10", obs_ready_done, obs_busy_done); end
        $display("txn %0d: done, txn_count=%0d", n_txn, obs_count_done);
    endtask

    task automatic test_partial();
        logic [127:0] w;
        w = {64'h0, 32'hB, 32'hA};
        drive_words(2, w, 1'b1, 1'b0);
        n_checks++; if (obs_data !== 128'h0000000B_0000000A) begin n_fail++; $display("FAIL partial_data got=%h want=%h", obs_data, 128'h0000000B_0000000A); end
        n_checks++; if (obs_start !== 1'b1 || obs_start_after !== 1'b0) begin n_fail++; $display("FAIL partial_start got=%b%b want=10", obs_start, obs_start_after); end
        n_checks++; if (obs_waddr !== 32'h1010) begin n_fail++; $display("FAIL partial_waddr got=%h want=00001010", obs_waddr); end
        n_txn++;
        $display("txn %0d: waddr=%h data=%h", n_txn, obs_waddr, obs_data);
        finish_txn(2);
        exp_count++; exp_addr += 32'd16;
        n_checks++; if (obs_count_done !== exp_count) begin n_fail++; $display("FAIL partial_count got=%0d want=%0d", obs_count_done, exp_count); end
    endtask

    task automatic test_base_ignored();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        drive_words(4, w, 1'b0, 1'b1);
        n_checks++; if (obs_waddr !== exp_addr || obs_data !== w) begin n_fail++; $display("FAIL ignore_fill got=%h/%h want=%h/%h", obs_waddr, obs_data, exp_addr, w); end
        n_txn++;
        $display("txn %0d: waddr=%h data=%h (base_load held)", n_txn, obs_waddr, obs_data);
        finish_txn(3);
        exp_count++; exp_addr += 32'd16;
        drive_words(1, {96'h0, 32'hCAFE}, 1'b1, 1'b0);
        n_checks++; if (obs_waddr !== 32'h1030) begin n_fail++; $display("FAIL ignore_next_waddr got=%h want=00001030", obs_waddr); end
        n_checks++; if (obs_data !== {96'h0, 32'hCAFE}) begin n_fail++; $display("FAIL single_word_data got=%h want=%h", obs_data, {96'h0, 32'hCAFE}); end
        n_txn++;
        $display("txn %0d: waddr=%h data=%h", n_txn, obs_waddr, obs_data);
        finish_txn(1);
        exp_count++; exp_addr += 32'd16;
    endtask

    task automatic test_addr_wrap();
        logic [127:0] w;
        base_load = 1'b1; base_addr = 32'hFFFF_FFF0;
        tick();
        base_load = 1'b0;
        exp_addr = 32'hFFFF_FFF0;
        w = {$urandom, $urandom, $urandom, $urandom};
        drive_words(4, w, 1'b0, 1'b0);
        n_checks++; if (obs_waddr !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL wrap_first_waddr got=%h want=fffffff0", obs_waddr); end
        n_txn++;
        $display("txn %0d: waddr=%h data=%h", n_txn, obs_waddr, obs_data);
        finish_txn(0);
        exp_count++; exp_addr += 32'd16;
        drive_words(3, w, 1'b1, 1'b0);
        n_checks++; if (obs_waddr !== 32'h0 || obs_raddr !== 32'h0) begin n_fail++; $display("FAIL wrap_waddr got=%h/%h want=00000000", obs_waddr, obs_raddr); end
        n_checks++; if (obs_data !== pack(w, 3)) begin n_fail++; $display("FAIL wrap_data got=%h want=%h", obs_data, pack(w, 3)); end
        n_txn++;
        $display("txn %0d: waddr=%h data=%h", n_txn, obs_waddr, obs_data);
        finish_txn(2);
        exp_count++; exp_addr += 32'd16;
    endtask

    task automatic test_stray_done();
        bus.txn_done = 1'b1;
        tick();
        tick();
        bus.txn_done = 1'b0;
        tick();
        n_checks++; if (txn_count !== exp_count) begin n_fail++; $display("FAIL stray_count got=%0d want=%0d", txn_count, exp_count); end
        n_checks++; if (bus.s_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL stray_state got=%b%b want=10", bus.s_ready, busy); end
        drive_words(1, {96'h0, 32'h1234}, 1'b1, 1'b0);
        n_checks++; if (obs_waddr !== exp_addr) begin n_fail++; $display("FAIL stray_addr got=%h want=%h", obs_waddr, exp_addr); end
        n_txn++;
        $display("txn %0d: waddr=%h after stray txn_done", n_txn, obs_waddr);
        finish_txn(1);
        exp_count++; exp_addr += 32'd16;
    endtask

    task automatic test_reset_mid();
        logic [127:0] w;
        int guard;
        bit saw_start;
        saw_start = 0;
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'hDEAD_0000 + i;
            guard = 0;
            while (bus.s_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
            n_checks++; if (guard >= 50) begin n_fail++; $display("FAIL midreset_handshake timeout word=%0d", i); end
            tick();
        end
        bus.s_valid = 1'b0;
        areset = 1'b0;
        #2;
        n_checks++; if (bus.data_in !== 128'h0 || bus.s_ready !== 1'b0 || busy !== 1'b0 || txn_count !== 16'h0 || bus.waddr !== 32'h0) begin
            n_fail++; $display("FAIL midreset_outputs got=data %h ready %b busy %b cnt %0d waddr %h want=all 0", bus.data_in, bus.s_ready, busy, txn_count, bus.waddr);
        end
        repeat (2) begin tick(); if (bus.start === 1'b1) saw_start = 1; end
        areset = 1'b1;
        exp_addr = 32'h0; exp_count = 16'h0;
        repeat (3) begin tick(); if (bus.start === 1'b1) saw_start = 1; end
        n_checks++; if (saw_start) begin n_fail++; $display("FAIL midreset_start got=1 want=0"); end
        w = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
        drive_words(4, w, 1'b0, 1'b0);
        n_checks++; if (obs_data !== w || obs_waddr !== 32'h0) begin n_fail++; $display("FAIL midreset_fresh got=%h/%h want=%h/00000000", obs_data, obs_waddr, w); end
        n_txn++;
        $display("txn %0d: waddr=%h data=%h after reset", n_txn, obs_waddr, obs_data);
        finish_txn(1);
        exp_count++; exp_addr += 32'd16;
        n_checks++; if (obs_count_done !== 16'd1) begin n_fail++; $display("FAIL midreset_count got=%0d want=1", obs_count_done); end
    endtask

    task automatic test_random();
        logic [127:0] w;
        int n;
        bit use_last;
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                base_load = 1'b1; base_addr = $urandom;
                tick();
                base_load = 1'b0;
                exp_addr = base_addr;
            end
            n = $urandom_range(1, BEATS);
            use_last = (n < BEATS) ? 1'b1 : 1'($urandom_range(0, 1));
            w = {$urandom, $urandom, $urandom, $urandom};
            drive_words(n, w, use_last, 1'b0);
            n_checks++; if (obs_timeout || obs_start !== 1'b1 || obs_start_after !== 1'b0) begin n_fail++; $display("FAIL rand_start t=%0d got=to %0d start %b%b want=to 0 start 10", t, obs_timeout, obs_start, obs_start_after); end
            n_checks++; if (obs_data !== pack(w, n)) begin n_fail++; $display("FAIL rand_data t=%0d got=%h want=%h", t, obs_data, pack(w, n)); end
            n_checks++; if (obs_waddr !== exp_addr || obs_raddr !== exp_addr) begin n_fail++; $display("FAIL rand_addr t=%0d got=%h/%h want=%h", t, obs_waddr, obs_raddr, exp_addr); end
            n_txn++;
            $display("txn %0d: words=%0d waddr=%h data=%h", n_txn, n, obs_waddr, obs_data);
            finish_txn($urandom_range(0, 4));
            exp_count++; exp_addr += 32'd16;
            n_checks++; if (obs_count_done !== exp_count || obs_ready_done !== 1'b1) begin n_fail++; $display("FAIL rand_done t=%0d got=cnt %0d ready %b want=cnt %0d ready 1", t, obs_count_done, obs_ready_done, exp_count); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_data   = 32'h0;
        bus.s_last   = 1'b0;
        bus.txn_done = 1'b0;
        test_reset();
        test_basic();
        test_done();
        test_partial();
        test_base_ignored();
        test_addr_wrap();
        test_stray_done();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
